mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- MEM-stage load/store unit; consumer side of the EX/MEM pipeline register.
- Takes the registered access request (cs, we, byte strobes, data, address) and runs it as a valid/grant/rvalid transaction on the data bus.
- Formats load data and forwards the writeback fields to MEM/WB.
- Requests a pipeline hold from ctrl until the access completes.

Parameters:
- DATA_W, 32, data bus and register width (`MemWidth / `RegWidth).
- ADDR_W, 32, bus address width (`MemAddrWidth).
- STRB_W, 4, byte strobes (`MemUnit), equal to DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- inst_i  in  32  instruction from EX/MEM; funct3 is inst_i[14:12]
- instaddr_i  in  32  instruction address
- cs_i  in  1  memory access request
- mem_we_i  in  1  1 = store, 0 = load
- mem_wem_i  in  STRB_W  store byte strobes, already lane-aligned by EX
- mem_din  in  DATA_W  store data, already lane-aligned
- mem_addr_i  in  ADDR_W  byte address
- regs_wen_i  in  1  register write enable
- rd_addr_i  in  5  destination register
- rd_data_i  in  DATA_W  ALU result
- bus_req_o  out  1  bus request valid
- bus_gnt_i  in  1  request accepted
- bus_we_o  out  1  write
- bus_wem_o  out  STRB_W  byte strobes
- bus_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00})
- bus_wdata_o  out  DATA_W  write data
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  DATA_W  read data
- inst_o, instaddr_o  out  32  pass-through to MEM/WB
- regs_wen_o  out  1  gated write enable
- rd_addr_o  out  5  pass-through
- rd_data_o  out  DATA_W  load result or rd_data_i
- hold_req_o  out  1  hold request to ctrl

Behaviour:
- States: IDLE, REQ, RESP, DONE. Reset value is IDLE.
  - IDLE: cs_i=1 -> REQ, capturing we/wem/addr/wdata/funct3 into request registers.
  - REQ: bus_req_o=1. On bus_gnt_i: store -> DONE; load -> RESP.
  - RESP: on bus_rvalid_i, capture bus_rdata_i into ld_data_r -> DONE.
  - DONE: one cycle, then -> IDLE unconditionally.
- rvalid is honoured only in RESP.
  - rvalid in the same cycle as gnt is a protocol violation; it is ignored.
  - rvalid seen in IDLE, REQ or DONE is ignored.
- bus_* outputs come only from the request registers. bus_req_o = (state==REQ), so there is no combinational path from cs_i to the bus.
- hold_req_o = (state==IDLE && cs_i) | (state==REQ) | (state==RESP). It is low in DONE, which lets EX/MEM advance; the IDLE that follows therefore sees the next instruction.
- regs_wen_o = regs_wen_i & ~hold_req_o.
- rd_data_o:
  - In DONE for a load: ld_data_r formatted by the captured funct3 and addr[1:0].
    - LB (000): sign-extended byte.
    - LH (001): sign-extended halfword at addr[1].
    - LW (010): full word.
    - LBU (100): zero-extended byte.
    - LHU (101): zero-extended halfword.
    - Any other funct3: full word.
  - Otherwise: rd_data_i.
- Latency:
  - Store with immediate gnt: 3 cycles (IDLE, REQ, DONE), hold for 2.
  - Load: 4 + gnt wait + rvalid wait.
- Back-to-back accesses: DONE -> IDLE -> REQ; no bubble beyond the DONE cycle.
- cs_i=0 instructions pass straight through with zero latency and no hold.
- Reset mid-transaction:
  - State -> IDLE on the next edge; bus_req_o drops at that edge.
  - Request registers and ld_data_r -> 0; hold_req_o follows cs_i.
- Output values while rst=1: bus_req_o=0, bus_we_o=0, bus_wem_o=0, bus_addr_o=0, bus_wdata_o=0. Pass-through outputs follow their inputs.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- With the macro, misaligned accesses are checked: a halfword at addr[0]=1, or a word at addr[1:0]!=0.
  - IDLE goes directly to DONE; no bus request is issued.
  - Extra port misalign_o (1 bit) is pulsed in DONE.
  - regs_wen_o is forced to 0 in DONE.
- Without the macro, there is no check and no misalign_o port. Misaligned accesses go to the bus word-aligned; loads use lane addr[1:0] as-is.

Decomposition:
- Shared defines:
  - state encodings LSU_IDLE/REQ/RESP/DONE;
  - funct3 constants LB/LH/LW/LBU/LHU;
  - existing `MemBus/`MemAddrBus/`MemUnit/`RegBus/`INST_NOP.
- One sub-module, lsu_ld_fmt: combinational load formatter (rdata, funct3, addr[1:0] -> DATA_W result). It is reusable by a future cache path.

Test Plan:
- SW: addr 0x100, wem 4'b1111, data 0xDEADBEEF, gnt on the first REQ cycle.
  - bus_addr_o=0x100, bus_we_o=1, bus_wem_o=4'b1111, bus_wdata_o=0xDEADBEEF.
  - hold_req_o high for exactly 2 cycles; regs_wen_o=0.
- LB: addr 0x103, rdata 0x80112233, gnt after 2 wait cycles, rvalid 1 cycle after gnt.
  - rd_data_o=0xFFFFFF80 in DONE; regs_wen_o=1 only in DONE.
- LHU: addr 0x102, rdata 0x8001_1234 -> rd_data_o=0x00008001.
- LH: addr 0x100, same rdata -> rd_data_o=0x00001234.
- Back-to-back LW then SW:
  - two separate bus transactions;
  - hold drops for exactly one cycle (DONE) between them;
  - a stray rvalid during the SW REQ is ignored.
- rst asserted in RESP:
  - next cycle state=IDLE, bus_req_o=0, hold_req_o=cs_i;
  - a late rvalid 0xAAAA5555 does not appear on rd_data_o.
- With LSU_MISALIGN_CHK_EN: LW at 0x102.
  - no bus_req_o;
  - misalign_o=1 for one cycle; regs_wen_o=0.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// The LSU_MISALIGN_CHK_EN build uses is_misaligned() for early access rejection.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3[1:0] encodes access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    return ((funct3[1:0] == 2'b01) && lane[0]) ||
           ((funct3[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_ld_fmt.sv
// Combinational load formatter: selects and extends the addressed byte/halfword
// of a bus word according to funct3.
module lsu_ld_fmt
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  output logic [DATA_W-1:0] result
);

  localparam int STRB_W = DATA_W / 8;

  logic [7:0]  lane_byte [STRB_W];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_byte
      assign lane_byte[gi] = rdata[gi*8 +: 8];
    end
  endgenerate

  assign byte_sel = lane_byte[lane];
  assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_LW:   result = rdata;
      F3_LBU:  result = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(DATA_W-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs EX/MEM access requests as valid/grant/rvalid
// bus transactions and holds the pipeline until done. Optional: LSU_MISALIGN_CHK_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       instaddr_i,
  input  logic              cs_i,
  input  logic              mem_we_i,
  input  logic [STRB_W-1:0] mem_wem_i,
  input  logic [DATA_W-1:0] mem_din,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              regs_wen_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic              bus_we_o,
  output logic [STRB_W-1:0] bus_wem_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       instaddr_o,
  output logic              regs_wen_o,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
`ifdef LSU_MISALIGN_CHK_EN
  output logic              misalign_o,
`endif
  output logic              hold_req_o
);

  lsu_state_t        state_reg, state_next;
  logic              we_reg;
  logic [STRB_W-1:0] wem_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [2:0]        funct3_reg;
  logic [DATA_W-1:0] ld_data_reg;
  logic [DATA_W-1:0] ld_fmt;
  logic              misalign_now;
  logic              misalign_done;

`ifdef LSU_MISALIGN_CHK_EN
  logic misalign_reg;

  assign misalign_now  = is_misaligned(inst_i[14:12], mem_addr_i[1:0]);
  assign misalign_done = (state_reg == LSU_DONE) && misalign_reg;
  assign misalign_o    = misalign_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else if (state_reg == LSU_IDLE && cs_i) begin
      misalign_reg <= misalign_now;
    end
  end
`else
  assign misalign_now  = 1'b0;
  assign misalign_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= LSU_IDLE;
      we_reg      <= 1'b0;
      wem_reg     <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      funct3_reg  <= '0;
      ld_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == LSU_IDLE && cs_i) begin
        we_reg     <= mem_we_i;
        wem_reg    <= mem_wem_i;
        addr_reg   <= mem_addr_i;
        wdata_reg  <= mem_din;
        funct3_reg <= inst_i[14:12];
      end
      // rvalid outside RESP (including alongside gnt) is deliberately dropped
      if (state_reg == LSU_RESP && bus_rvalid_i) begin
        ld_data_reg <= bus_rdata_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LSU_IDLE: if (cs_i)         state_next = misalign_now ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (bus_gnt_i)    state_next = we_reg ? LSU_DONE : LSU_RESP;
      LSU_RESP: if (bus_rvalid_i) state_next = LSU_DONE;
      LSU_DONE:                   state_next = LSU_IDLE;
      default:                    state_next = LSU_IDLE;
    endcase
  end

  lsu_ld_fmt #(.DATA_W(DATA_W)) u_ld_fmt (
    .rdata  (ld_data_reg),
    .funct3 (funct3_reg),
    .lane   (addr_reg[1:0]),
    .result (ld_fmt)
  );

  // Bus side is driven purely from registers; no combinational path from cs_i
  assign bus_req_o   = (state_reg == LSU_REQ);
  assign bus_we_o    = we_reg;
  assign bus_wem_o   = wem_reg;
  assign bus_addr_o  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign bus_wdata_o = wdata_reg;

  assign hold_req_o = ((state_reg == LSU_IDLE) && cs_i) ||
                      (state_reg == LSU_REQ) || (state_reg == LSU_RESP);

  assign inst_o     = inst_i;
  assign instaddr_o = instaddr_i;
  assign rd_addr_o  = rd_addr_i;
  assign regs_wen_o = regs_wen_i && !hold_req_o && !misalign_done;
  assign rd_data_o  = ((state_reg == LSU_DONE) && !we_reg) ? ld_fmt : rd_data_i;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed accesses with a bus-transaction and
// writeback scoreboard. Define LSU_MISALIGN_CHK_EN to exercise the misalign check.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk, rst;
  logic [31:0] inst, instaddr;
  logic        cs, we;
  logic [3:0]  wem;
  logic [31:0] din, addr;
  logic        regs_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        bus_req_o, bus_gnt, bus_we_o, bus_rvalid;
  logic [3:0]  bus_wem_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata;
  logic [31:0] inst_o, instaddr_o, rd_data_o;
  logic        regs_wen_o, hold_req_o;
  logic [4:0]  rd_addr_o;
`ifdef LSU_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [68:0] bus_q[$];
  logic [36:0] wb_q[$];

  mem_lsu dut (
    .clk(clk), .rst(rst), .inst_i(inst), .instaddr_i(instaddr), .cs_i(cs),
    .mem_we_i(we), .mem_wem_i(wem), .mem_din(din), .mem_addr_i(addr),
    .regs_wen_i(regs_wen), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt), .bus_we_o(bus_we_o),
    .bus_wem_o(bus_wem_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata), .inst_o(inst_o),
    .instaddr_o(instaddr_o), .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o),
`ifdef LSU_MISALIGN_CHK_EN
    .misalign_o(misalign_o),
`endif
    .hold_req_o(hold_req_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pops: bus transaction on accepted request, writeback on regs_wen_o
  task automatic monitor();
    logic [68:0] b;
    logic [36:0] w;
    if (bus_req_o && bus_gnt) begin
      if (bus_q.size() == 0) chk("bus_unexpected", bus_req_o, 1'b0);
      else begin
        b = bus_q.pop_front();
        chk("bus_txn", {bus_we_o, bus_wem_o, bus_addr_o, bus_wdata_o}, b);
        $display("bus txn we=%0b wem=%h addr=%h wdata=%h", bus_we_o, bus_wem_o, bus_addr_o, bus_wdata_o);
      end
    end
    if (regs_wen_o) begin
      if (wb_q.size() == 0) chk("wb_unexpected", regs_wen_o, 1'b0);
      else begin
        w = wb_q.pop_front();
        chk("wb_data", {rd_addr_o, rd_data_o}, w);
        $display("writeback rd=%0d data=%h", rd_addr_o, rd_data_o);
      end
    end
  endtask

  task automatic next_cycle();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input string name, input logic we_t, input logic [3:0] wem_t,
                        input logic [31:0] addr_t, input logic [31:0] din_t,
                        input logic [2:0] f3, input logic wen_t, input logic [4:0] rd_t,
                        input logic [31:0] rdat, input int gnt_wait, input int rv_wait,
                        input logic [31:0] exp_rd, input bit stray_rv);
    int  hold_cnt = 0;
    int  req_cnt = 0;
    int  since_gnt = 0;
    int  cyc = 0;
    int  exp_hold;
    bit  granted = 0;
    bit  done = 0;
    bit  wen_bad = 0;
    exp_hold = we_t ? (2 + gnt_wait) : (3 + gnt_wait + rv_wait);
    inst = {17'd0, f3, rd_t, 7'h03};
    instaddr = instaddr + 32'd4;
    cs = 1'b1; we = we_t; wem = wem_t; addr = addr_t; din = din_t;
    regs_wen = wen_t; rd_addr = rd_t; rd_data = 32'h5A5A_0000 | addr_t;
    bus_q.push_back({we_t, wem_t, {addr_t[31:2], 2'b00}, din_t});
    if (wen_t) wb_q.push_back({rd_t, exp_rd});
    while (!done && cyc < 50) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = rdat;
      if (bus_req_o) begin
        bus_gnt = (req_cnt == gnt_wait);
        req_cnt++;
        if (stray_rv) begin bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0; end
      end else if (granted) begin
        since_gnt++;
        bus_rvalid = (since_gnt == rv_wait + 1);
      end
      if (bus_gnt) granted = 1;
      #1;
      if (cyc == 0) chk({name, "_hold_first"}, hold_req_o, 1'b1);
      if (hold_req_o) begin
        hold_cnt++;
        if (regs_wen_o) wen_bad = 1;
      end else begin
        done = 1;
        chk({name, "_wen_done"}, regs_wen_o, wen_t);
      end
      cyc++;
      next_cycle();
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    chk({name, "_timeout"}, done, 1'b1);
    chk({name, "_hold_cycles"}, hold_cnt, exp_hold);
    chk({name, "_wen_in_hold"}, wen_bad, 1'b0);
    $display("%s: addr=%h hold=%0d cycles", name, addr_t, hold_cnt);
  endtask

  initial begin
    rst = 1'b1; inst = 32'h13; instaddr = 32'h1000; cs = 0; we = 0; wem = 0;
    din = 0; addr = 0; regs_wen = 0; rd_addr = 0; rd_data = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_bus_req", bus_req_o, 1'b0);
    chk("rst_hold", hold_req_o, 1'b0);
    chk("rst_bus_fields", {bus_we_o, bus_wem_o, bus_addr_o, bus_wdata_o}, 69'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Non-memory instruction passes straight through
    cs = 0; regs_wen = 1; rd_addr = 5'd5; rd_data = 32'h1234_5678;
    inst = 32'h0050_0293; instaddr = 32'h2000;
    wb_q.push_back({5'd5, 32'h1234_5678});
    #1;
    chk("pass_hold", hold_req_o, 1'b0);
    chk("pass_inst", {inst_o, instaddr_o}, {32'h0050_0293, 32'h2000});
    chk("pass_bus_req", bus_req_o, 1'b0);
    next_cycle();

    access("sw",  1'b1, 4'b1111, 32'h100, 32'hDEAD_BEEF, 3'b010, 1'b0, 5'd0,
           32'h0, 0, 0, 32'h0, 1'b0);
    access("lb",  1'b0, 4'b0000, 32'h103, 32'h0, F3_LB, 1'b1, 5'd6,
           32'h8011_2233, 2, 0, 32'hFFFF_FF80, 1'b0);
    access("lbu", 1'b0, 4'b0000, 32'h103, 32'h0, F3_LBU, 1'b1, 5'd7,
           32'h8011_2233, 0, 1, 32'h0000_0080, 1'b0);
    access("lhu", 1'b0, 4'b0000, 32'h102, 32'h0, F3_LHU, 1'b1, 5'd8,
           32'h8001_1234, 0, 0, 32'h0000_8001, 1'b0);
    access("lh",  1'b0, 4'b0000, 32'h100, 32'h0, F3_LH, 1'b1, 5'd9,
           32'h8001_1234, 1, 2, 32'h0000_1234, 1'b0);
    // Back-to-back LW then SW with stray rvalid in each REQ phase
    access("lw_b2b", 1'b0, 4'b0000, 32'h104, 32'h0, F3_LW, 1'b1, 5'd10,
           32'hCAFE_F00D, 1, 1, 32'hCAFE_F00D, 1'b1);
    access("sw_b2b", 1'b1, 4'b0011, 32'h108, 32'h0000_BEEF, 3'b001, 1'b0, 5'd0,
           32'h0, 1, 0, 32'h0, 1'b1);

    // Load aborted by reset while waiting for rvalid
    inst = {17'd0, F3_LW, 5'd2, 7'h03}; cs = 1; we = 0; wem = 0; addr = 32'h200;
    din = 0; regs_wen = 1; rd_addr = 5'd2;
    bus_q.push_back({1'b0, 4'h0, 32'h200, 32'h0});
    #1; next_cycle();
    bus_gnt = 1; #1;
    chk("rst_seq_req", bus_req_o, 1'b1);
    next_cycle();
    bus_gnt = 0; rst = 1; #1;
    chk("rst_seq_resp_hold", hold_req_o, 1'b1);
    next_cycle();
    chk("rst_mid_bus_req", bus_req_o, 1'b0);
    chk("rst_mid_hold", hold_req_o, cs);
    chk("rst_mid_bus_fields", {bus_we_o, bus_wem_o, bus_addr_o, bus_wdata_o}, 69'd0);
    rst = 0; cs = 0; bus_rvalid = 1; bus_rdata = 32'hAAAA_5555;
    rd_data = 32'h1111_1111; rd_addr = 5'd3; regs_wen = 1;
    wb_q.push_back({5'd3, 32'h1111_1111});
    #1;
    chk("late_rvalid_data", rd_data_o, 32'h1111_1111);
    chk("late_rvalid_hold", hold_req_o, 1'b0);
    next_cycle();
    bus_rvalid = 0; regs_wen = 0;
    #1;
    chk("after_rst_idle", bus_req_o, 1'b0);
    next_cycle();

`ifdef LSU_MISALIGN_CHK_EN
    // Misaligned word load completes without touching the bus
    inst = {17'd0, F3_LW, 5'd4, 7'h03}; cs = 1; we = 0; addr = 32'h102;
    regs_wen = 1; rd_addr = 5'd4;
    #1;
    chk("mis_idle_hold", hold_req_o, 1'b1);
    next_cycle();
    #1;
    chk("mis_bus_req", bus_req_o, 1'b0);
    chk("mis_flag", misalign_o, 1'b1);
    chk("mis_wen", regs_wen_o, 1'b0);
    chk("mis_hold", hold_req_o, 1'b0);
    next_cycle();
    cs = 0; regs_wen = 0; #1;
    chk("mis_flag_clear", misalign_o, 1'b0);
    chk("mis_bus_req_after", bus_req_o, 1'b0);
    next_cycle();
`endif

    chk("bus_q_drained", bus_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
